// File: rtl/dr_clk_fifo_if.sv
// Dual-rail link bundle between the clocked FIFO (slave) and its self-timed neighbours (master).
interface dr_clk_fifo_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned RW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [RW-1:0] in_rails;
    logic          ack_in;
    logic [RW-1:0] out_rails;
    logic          ack_out;
    logic [CW-1:0] count;
    logic          err;

    modport master (
        output in_rails,
        output ack_out,
        input  ack_in,
        input  out_rails,
        input  count,
        input  err
    );

    modport slave (
        input  in_rails,
        input  ack_out,
        output ack_in,
        output out_rails,
        output count,
        output err
    );
endinterface

// File: rtl/dr_clk_fifo.sv
// Clocked FIFO bridging two self-timed dual-rail links, four-phase RTZ ("FP") or two-phase ("TP").
// Synchronises incoming rails and ack, tracks occupancy and flags illegal rail codes.
module dr_clk_fifo #(
    parameter              ENC   = "FP",
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SYNC  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    dr_clk_fifo_if.slave  bus
);
    localparam int unsigned RW    = 2 * WIDTH;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned PW    = $clog2(DEPTH);
    localparam bit          IS_TP = (ENC == "TP");

    if ((ENC != "FP") && (ENC != "TP")) begin : g_bad_enc
        $error("dr_clk_fifo: ENC must be \"FP\" or \"TP\"");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("dr_clk_fifo: DEPTH must be a power of two >= 2");
    end
    if (SYNC < 2) begin : g_bad_sync
        $error("dr_clk_fifo: SYNC must be >= 2");
    end

    typedef enum logic {IN_IDLE, IN_WAIT_SP} in_st_e;
    typedef enum logic [1:0] {OUT_EMPTY, OUT_DRIVE, OUT_RTZ} out_st_e;

    logic [RW-1:0]    sync_q [SYNC];
    logic [SYNC-1:0]  sack_q;
    logic [RW-1:0]    sin;
    logic             sack;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             err_q, err_d;
    logic             ack_in_q, ack_in_d;
    logic [RW-1:0]    rin_ref_q, rin_ref_d;
    logic [RW-1:0]    out_q, out_d;
    logic             exp_ack_q, exp_ack_d;
    in_st_e           in_st_q, in_st_d;
    out_st_e          out_st_q, out_st_d;

    logic [RW-1:0]    in_diff;
    logic [WIDTH-1:0] in_word;
    logic             in_complete, in_err, in_spacer;
    logic             full, wr_en, pop;
    logic [WIDTH-1:0] head_word, nxt_word;

    function automatic logic [RW-1:0] rail_sel(input logic [WIDTH-1:0] w);
        logic [RW-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[2*i]   = ~w[i];
            r[2*i+1] = w[i];
        end
        return r;
    endfunction

    // Synchronisers for the incoming rails and the downstream ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC; s++) sync_q[s] <= '0;
            sack_q <= '0;
        end else begin
            sync_q[0] <= bus.in_rails;
            for (int s = 1; s < SYNC; s++) sync_q[s] <= sync_q[s-1];
            sack_q <= {sack_q[SYNC-2:0], bus.ack_out};
        end
    end

    assign sin  = sync_q[SYNC-1];
    assign sack = sack_q[SYNC-1];

    // In TP mode a rail "asserts" by differing from the level last accepted.
    assign in_diff   = IS_TP ? (sin ^ rin_ref_q) : sin;
    assign in_spacer = (sin == '0);

    always_comb begin
        in_complete = 1'b1;
        in_err      = 1'b0;
        in_word     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            in_complete = in_complete & (in_diff[2*i] ^ in_diff[2*i+1]);
            in_err      = in_err | (in_diff[2*i] & in_diff[2*i+1]);
            in_word[i]  = in_diff[2*i+1];
        end
    end

    assign full      = (count_q == CW'(DEPTH));
    assign head_word = mem_q[rd_ptr_q];
    assign nxt_word  = mem_q[rd_ptr_q + PW'(1)];

    // Input side: accept a complete word when not full, answer on ack_in.
    always_comb begin
        in_st_d   = in_st_q;
        ack_in_d  = ack_in_q;
        rin_ref_d = rin_ref_q;
        wr_en     = 1'b0;
        if (IS_TP) begin
            if (in_complete && !full) begin
                wr_en     = 1'b1;
                rin_ref_d = sin;
                ack_in_d  = ~ack_in_q;
            end
        end else begin
            case (in_st_q)
                IN_IDLE: begin
                    if (in_complete && !full) begin
                        wr_en    = 1'b1;
                        ack_in_d = 1'b1;
                        in_st_d  = IN_WAIT_SP;
                    end
                end
                IN_WAIT_SP: begin
                    if (in_spacer) begin
                        ack_in_d = 1'b0;
                        in_st_d  = IN_IDLE;
                    end
                end
                default: in_st_d = IN_IDLE;
            endcase
        end
    end

    // Output side: present the head word, pop once the receiver acknowledges.
    always_comb begin
        out_st_d  = out_st_q;
        out_d     = out_q;
        exp_ack_d = exp_ack_q;
        pop       = 1'b0;
        if (IS_TP) begin
            case (out_st_q)
                OUT_EMPTY: begin
                    if (count_q != '0) begin
                        out_d     = out_q ^ rail_sel(head_word);
                        exp_ack_d = ~exp_ack_q;
                        out_st_d  = OUT_DRIVE;
                    end
                end
                OUT_DRIVE: begin
                    if (sack == exp_ack_q) begin
                        pop = 1'b1;
                        if (count_q > CW'(1)) begin
                            out_d     = out_q ^ rail_sel(nxt_word);
                            exp_ack_d = ~exp_ack_q;
                        end else begin
                            out_st_d = OUT_EMPTY;
                        end
                    end
                end
                default: out_st_d = OUT_EMPTY;
            endcase
        end else begin
            case (out_st_q)
                OUT_EMPTY: begin
                    if (count_q != '0) begin
                        out_d    = rail_sel(head_word);
                        out_st_d = OUT_DRIVE;
                    end
                end
                OUT_DRIVE: begin
                    if (sack) begin
                        out_d    = '0;
                        pop      = 1'b1;
                        out_st_d = OUT_RTZ;
                    end
                end
                OUT_RTZ: begin
                    if (!sack) begin
                        if (count_q != '0) begin
                            out_d    = rail_sel(head_word);
                            out_st_d = OUT_DRIVE;
                        end else begin
                            out_st_d = OUT_EMPTY;
                        end
                    end
                end
                default: out_st_d = OUT_EMPTY;
            endcase
        end
    end

    assign count_d = count_q + CW'(wr_en) - CW'(pop);
    assign err_d   = err_q | in_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_st_q   <= IN_IDLE;
            out_st_q  <= OUT_EMPTY;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
            ack_in_q  <= 1'b0;
            rin_ref_q <= '0;
            out_q     <= '0;
            exp_ack_q <= 1'b0;
        end else begin
            in_st_q   <= in_st_d;
            out_st_q  <= out_st_d;
            wr_ptr_q  <= wr_ptr_q + PW'(wr_en);
            rd_ptr_q  <= rd_ptr_q + PW'(pop);
            count_q   <= count_d;
            err_q     <= err_d;
            ack_in_q  <= ack_in_d;
            rin_ref_q <= rin_ref_d;
            out_q     <= out_d;
            exp_ack_q <= exp_ack_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= in_word;
    end

    assign bus.ack_in    = ack_in_q;
    assign bus.out_rails = out_q;
    assign bus.count     = count_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_dr_clk_fifo.sv
// Scoreboard bench: one four-phase (8-bit) and one two-phase (4-bit) FIFO, receiver monitors check words in order.
module tb_dr_clk_fifo;
    localparam int unsigned AW    = 8;
    localparam int unsigned BW    = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned SYNC  = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dr_clk_fifo_if #(.WIDTH(AW), .DEPTH(DEPTH)) a_if ();
    dr_clk_fifo_if #(.WIDTH(BW), .DEPTH(DEPTH)) b_if ();

    dr_clk_fifo #(.ENC("FP"), .WIDTH(AW), .DEPTH(DEPTH), .SYNC(SYNC)) u_fp (
        .clk(clk), .rst_n(rst_n), .bus(a_if.slave));
    dr_clk_fifo #(.ENC("TP"), .WIDTH(BW), .DEPTH(DEPTH), .SYNC(SYNC)) u_tp (
        .clk(clk), .rst_n(rst_n), .bus(b_if.slave));

    int n_tests = 0;
    int n_fail  = 0;

    logic [AW-1:0]   a_q [$];
    logic [BW-1:0]   b_q [$];
    int              a_rx_cnt = 0, b_rx_cnt = 0;
    bit              a_rx_en = 1'b1;
    int              a_dly = 0, b_dly = 0;
    logic [2*AW-1:0] a_last_rails = '0;
    logic [2*BW-1:0] b_in = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [2*AW-1:0] enc_a(input logic [AW-1:0] w);
        logic [2*AW-1:0] r;
        for (int i = 0; i < AW; i++) begin
            r[2*i]   = ~w[i];
            r[2*i+1] = w[i];
        end
        return r;
    endfunction

    // Four-phase receiver: decode a complete word, compare, ack, wait for spacer.
    initial begin
        logic [AW-1:0] w;
        logic          ok;
        int            n;
        a_if.ack_out = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                a_if.ack_out = 1'b0;
                continue;
            end
            if (!a_rx_en || a_if.out_rails == '0) continue;
            ok = 1'b1;
            for (int i = 0; i < AW; i++) begin
                ok   = ok & (a_if.out_rails[2*i] ^ a_if.out_rails[2*i+1]);
                w[i] = a_if.out_rails[2*i+1];
            end
            a_last_rails = a_if.out_rails;
            check("fp_out_valid", 32'(ok), 1);
            check("fp_q_nonempty", 32'(a_q.size() != 0), 1);
            if (a_q.size() != 0) check("fp_word", 32'(w), 32'(a_q.pop_front()));
            a_rx_cnt++;
            repeat ($urandom_range(a_dly)) @(negedge clk);
            a_if.ack_out = 1'b1;
            n = 0;
            while (a_if.out_rails != '0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("fp_rtz_seen", 32'(a_if.out_rails == '0), 1);
            a_if.ack_out = 1'b0;
        end
    end

    // Two-phase receiver: any rail change must be one transition per bit.
    initial begin
        logic [2*BW-1:0] prev, d;
        logic [BW-1:0]   w;
        logic            ok;
        prev = '0;
        b_if.ack_out = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prev = '0;
                b_if.ack_out = 1'b0;
                continue;
            end
            if (b_if.out_rails == prev) continue;
            d  = b_if.out_rails ^ prev;
            ok = 1'b1;
            for (int i = 0; i < BW; i++) begin
                ok   = ok & (d[2*i] ^ d[2*i+1]);
                w[i] = d[2*i+1];
            end
            prev = b_if.out_rails;
            check("tp_out_valid", 32'(ok), 1);
            check("tp_q_nonempty", 32'(b_q.size() != 0), 1);
            if (b_q.size() != 0) check("tp_word", 32'(w), 32'(b_q.pop_front()));
            b_rx_cnt++;
            repeat ($urandom_range(b_dly)) @(negedge clk);
            b_if.ack_out = ~b_if.ack_out;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("fp_count_range", (32'(a_if.count) <= DEPTH) ? 32'd1 : 32'd0, 1);
            check("tp_count_range", (32'(b_if.count) <= DEPTH) ? 32'd1 : 32'd0, 1);
        end
    end

    task automatic send_a(input logic [AW-1:0] w);
        int n;
        a_q.push_back(w);
        a_if.in_rails = enc_a(w);
        n = 0;
        do begin @(negedge clk); n++; end while (a_if.ack_in !== 1'b1 && n < 200);
        check("fp_ack_rise", 32'(a_if.ack_in), 1);
        a_if.in_rails = '0;
        n = 0;
        do begin @(negedge clk); n++; end while (a_if.ack_in !== 1'b0 && n < 50);
        check("fp_ack_fall", 32'(a_if.ack_in), 0);
    endtask

    task automatic send_b(input logic [BW-1:0] w);
        logic prev, want;
        int   n;
        b_q.push_back(w);
        prev = b_if.ack_in;
        want = ~prev;
        for (int i = 0; i < BW; i++) b_in[2*i + int'(w[i])] = ~b_in[2*i + int'(w[i])];
        b_if.in_rails = b_in;
        n = 0;
        do begin @(negedge clk); n++; end while (b_if.ack_in === prev && n < 100);
        check("tp_ack_toggle", 32'(b_if.ack_in), 32'(want));
    endtask

    task automatic drain_a(input string name);
        int n;
        n = 0;
        while ((a_q.size() != 0 || a_if.count != '0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({name, "_queue_empty"}, 32'(a_q.size()), 0);
        check({name, "_count_zero"}, 32'(a_if.count), 0);
    endtask

    initial begin
        int n;
        int rx0;
        a_if.in_rails = '0;
        b_if.in_rails = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_fp_ack_in", 32'(a_if.ack_in), 0);
        check("rst_fp_out", 32'(a_if.out_rails), 0);
        check("rst_fp_count", 32'(a_if.count), 0);
        check("rst_fp_err", 32'(a_if.err), 0);
        check("rst_tp_ack_in", 32'(b_if.ack_in), 0);
        check("rst_tp_out", 32'(b_if.out_rails), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single word 0xA5: ack latency SYNC+1, rails 0x9966, then back to empty.
        a_q.push_back(8'hA5);
        a_if.in_rails = 16'h9966;
        n = 0;
        do begin @(negedge clk); n++; end while (a_if.ack_in !== 1'b1 && n < 20);
        check("t1_ack_latency", n, SYNC + 1);
        check("t1_count_one", 32'(a_if.count), 1);
        a_if.in_rails = '0;
        n = 0;
        do begin @(negedge clk); n++; end while (a_if.ack_in !== 1'b0 && n < 20);
        check("t1_ack_fall", 32'(a_if.ack_in), 0);
        drain_a("t1");
        check("t1_rx_cnt", a_rx_cnt, 1);
        check("t1_out_rails", 32'(a_last_rails), 32'h9966);
        check("t1_out_rtz", 32'(a_if.out_rails), 0);

        // Stalled receiver: four words fill the FIFO, the fifth waits for a pop.
        a_rx_en = 1'b0;
        rx0 = a_rx_cnt;
        for (int k = 1; k <= 4; k++) send_a(AW'(k));
        check("t2_count_full", 32'(a_if.count), 4);
        a_q.push_back(8'h05);
        a_if.in_rails = enc_a(8'h05);
        repeat (8) @(negedge clk);
        check("t2_no_ack_when_full", 32'(a_if.ack_in), 0);
        check("t2_count_held", 32'(a_if.count), 4);
        a_rx_en = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (a_if.ack_in !== 1'b1 && n < 100);
        check("t2_fifth_acked", 32'(a_if.ack_in), 1);
        check("t2_after_pop", (a_rx_cnt - rx0 >= 1) ? 32'd1 : 32'd0, 1);
        a_if.in_rails = '0;
        n = 0;
        do begin @(negedge clk); n++; end while (a_if.ack_in !== 1'b0 && n < 20);
        drain_a("t2");
        check("t2_rx_cnt", a_rx_cnt - rx0, 5);

        // Streaming with random receiver delays.
        a_dly = 5;
        rx0 = a_rx_cnt;
        for (int k = 0; k < 64; k++) send_a(AW'($urandom));
        drain_a("t3");
        check("t3_rx_cnt", a_rx_cnt - rx0, 64);
        check("t3_err_clear", 32'(a_if.err), 0);
        a_dly = 0;

        // Two-phase: 0x3, 0xC, 0xF leave the out rails at 0x5A^0xA5^0xAA = 0x55.
        b_dly = 1;
        send_b(4'h3);
        send_b(4'hC);
        send_b(4'hF);
        n = 0;
        while ((b_q.size() != 0 || b_if.count != '0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t4_rx_cnt", b_rx_cnt, 3);
        check("t4_count_zero", 32'(b_if.count), 0);
        check("t4_out_rails", 32'(b_if.out_rails), 32'h55);
        check("t4_ack_in_level", 32'(b_if.ack_in), 1);
        check("t4_err_clear", 32'(b_if.err), 0);

        // Bit 2 with both rails high: sticky error, nothing written.
        a_if.in_rails = 16'h0030;
        n = 0;
        do begin @(negedge clk); n++; end while (a_if.err !== 1'b1 && n < 6);
        check("t5_err_set", 32'(a_if.err), 1);
        check("t5_count_unchanged", 32'(a_if.count), 0);
        check("t5_no_ack", 32'(a_if.ack_in), 0);
        a_if.in_rails = '0;
        repeat (5) @(negedge clk);
        check("t5_err_sticky", 32'(a_if.err), 1);
        check("t5_count_still_zero", 32'(a_if.count), 0);

        // Reset with three words stored and ack_in high.
        a_rx_en = 1'b0;
        send_a(8'h11);
        send_a(8'h22);
        a_q.push_back(8'h33);
        a_if.in_rails = enc_a(8'h33);
        n = 0;
        do begin @(negedge clk); n++; end while (a_if.ack_in !== 1'b1 && n < 20);
        check("t6_count_three", 32'(a_if.count), 3);
        check("t6_out_busy", 32'(a_if.out_rails != '0), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_ack_in", 32'(a_if.ack_in), 0);
        check("t6_rst_out", 32'(a_if.out_rails), 0);
        check("t6_rst_count", 32'(a_if.count), 0);
        check("t6_rst_err", 32'(a_if.err), 0);
        a_q.delete();
        b_q.delete();
        a_if.in_rails = '0;
        b_in = '0;
        b_if.in_rails = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        a_rx_en = 1'b1;
        @(negedge clk);
        rx0 = a_rx_cnt;
        send_a(8'h5A);
        drain_a("t6");
        check("t6_rx_after_reset", a_rx_cnt - rx0, 1);
        check("t6_rails_after_reset", 32'(a_last_rails), 32'h6699);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
